adder_bist: RTL and testbench

Self-checking built-in test controller for the team's ripple-carry adder cells. It drives every `{a, b, cin}` combination into an external adder, waits a programmable settle time, and samples the adder's sum and carry. It compares each sample against an internal reference and reports pass/fail, an error count and the first failing vector. It sits beside the adder under test in the lab top level, replacing the simulation-only stimulus fixture with a synthesizable generator and checker.

---
 rtl/adder_bist.sv | 119 +++++++++++
 tb/tb_adder_bist.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist.sv
// Built-in self-test controller: sweeps every {a, b, c0} into an external adder and checks {c1, s}.
// Optional build macro ADDER_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module adder_bist #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 c0,
    input  logic [WIDTH-1:0]     s,
    input  logic                 c1,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     fail_vec
);

    localparam int VW = 2*WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [VW-1:0] r_vec;
    logic [CW-1:0] r_cnt;
    logic [VW:0]   r_err;
    logic [VW-1:0] r_fail;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;

    logic [WIDTH:0] w_exp;
    logic           w_mismatch;
    logic           w_start_ok;
    logic           w_settled;
    logic           w_finish;

    // The adder response is only consumed in CHECK, so s/c1 never reach an output combinationally.
    assign w_exp      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c0};
    assign w_mismatch = ({c1, s} != w_exp);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_settled  = (r_cnt == CW'(SETTLE - 1));
    assign w_finish   = (&r_vec) || (STOP_ON_FAIL && w_mismatch);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_APPLY: begin
                    if (w_settled) begin
                        r_cnt   <= '0;
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= r_err + (VW+1)'(1);
                        if (r_err == '0)
                            r_fail <= r_vec;
                    end
                    if (w_finish) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !w_mismatch && (r_err == '0);
                    end else begin
                        r_vec   <= r_vec + VW'(1);
                        r_state <= S_APPLY;
                    end
                end
                default: begin
                    if (w_start_ok) begin
                        r_vec   <= '0;
                        r_cnt   <= '0;
                        r_err   <= '0;
                        r_fail  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_state <= S_APPLY;
                    end
                end
            endcase
        end
    end

    assign a         = r_vec[VW-1 -: WIDTH];
    assign b         = r_vec[WIDTH:1];
    assign c0        = r_vec[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist (WIDTH=1, SETTLE=2) driving a fault-injectable behavioural adder.
module tb_adder_bist;

    localparam int W    = 1;
    localparam int SET  = 2;
    localparam int NV   = 8;
    localparam int WIN  = SET + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c0;
    logic [W-1:0] s;
    logic         c1;
    logic         busy;
    logic         done;
    logic         pass;
    logic [3:0]   err_count;
    logic [2:0]   fail_vec;

    int n_checks;
    int n_fail;

    // 0: good adder, 1: carry-out stuck at 0, 2: inverted sum, 3: per-vector random corruption
    int       fault_mode;
    logic [1:0] ftab [NV];

    adder_bist #(.WIDTH(W), .SETTLE(SET)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .c0(c0), .s(s), .c1(c1),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] tb_good;
    logic [1:0] tb_out;
    always_comb begin
        tb_good = {1'b0, a} + {1'b0, b} + {1'b0, c0};
        tb_out  = tb_good;
        case (fault_mode)
            1:       tb_out = {1'b0, tb_good[0]};
            2:       tb_out = tb_good ^ 2'b01;
            3:       tb_out = tb_good ^ ftab[{a, b, c0}];
            default: tb_out = tb_good;
        endcase
    end
    assign {c1, s} = tb_out;

    function automatic int observed(input int mode, input int v);
        int av, bv, cv, sum;
        av  = (v >> 2) & 1;
        bv  = (v >> 1) & 1;
        cv  = v & 1;
        sum = av + bv + cv;
        case (mode)
            1:       return sum % 2;
            2:       return sum ^ 1;
            3:       return sum ^ int'(ftab[v]);
            default: return sum;
        endcase
    endfunction

    task automatic model(input int mode, output int e_err, output int e_first, output int e_len);
        e_err   = 0;
        e_first = 0;
        e_len   = NV * WIN;
        for (int v = 0; v < NV; v++) begin
            if (observed(mode, v) != ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1)) begin
                if (e_err == 0) e_first = v;
                e_err++;
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
                e_len = (v + 1) * WIN;
                break;
`endif
            end
        end
    endtask

    task automatic do_run(input string name, input int mode, input int repulse_at);
        int e_err, e_first, e_len, cycles, order_err;
        fault_mode = mode;
        model(mode, e_err, e_first, e_len);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || err_count !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_start: busy=%b done=%b err=%0d, required busy=1 done=0 err=0", name, busy, done, err_count);
        end
        cycles    = 1;
        order_err = 0;
        if ({a, b, c0} !== 3'(0)) order_err++;
        while (busy === 1'b1 && cycles < 200) begin
            if (cycles == repulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (busy === 1'b1) begin
                if (int'({a, b, c0}) != cycles / WIN) order_err++;
                cycles++;
            end
        end
        n_checks++;
        if (cycles >= 200) begin
            n_fail++;
            $display("FAIL %s_timeout: busy still high after %0d cycles, required %0d", name, cycles, e_len);
        end else if (cycles != e_len) begin
            n_fail++;
            $display("FAIL %s_busy_len: got %0d cycles, required %0d", name, cycles, e_len);
        end
        n_checks++;
        if (order_err != 0) begin
            n_fail++;
            $display("FAIL %s_vec_order: %0d off-sequence samples, required 0", name, order_err);
        end
        n_checks++;
        if (done !== 1'b1 || pass !== (e_err == 0)) begin
            n_fail++;
            $display("FAIL %s_done_pass: done=%b pass=%b, required done=1 pass=%b", name, done, pass, e_err == 0);
        end
        n_checks++;
        if (int'(err_count) != e_err) begin
            n_fail++;
            $display("FAIL %s_err_count: got %0d, required %0d", name, err_count, e_err);
        end
        if (e_err != 0) begin
            n_checks++;
            if (int'(fail_vec) != e_first) begin
                n_fail++;
                $display("FAIL %s_fail_vec: got %0d, required %0d", name, fail_vec, e_first);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || int'(err_count) != e_err) begin
            n_fail++;
            $display("FAIL %s_hold: done=%b busy=%b err=%0d, required 1 0 %0d", name, done, busy, err_count, e_err);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({a, b, c0, busy, done, pass, err_count, fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%h, required 0", {a, b, c0, busy, done, pass, err_count, fail_vec});
        end
    endtask

    task automatic test_good_adder();       do_run("good", 0, -1);       endtask
    task automatic test_carry_stuck();      do_run("c1_stuck0", 1, -1);  endtask
    task automatic test_inverted_sum();     do_run("inv_sum", 2, -1);    endtask
    task automatic test_restart_ignored();  do_run("repulse", 0, 5);     endtask

    task automatic test_start_in_done();
        do_run("pre_done", 2, -1);
        do_run("from_done", 0, -1);
    endtask

    task automatic test_async_reset();
        fault_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a, b, c0, busy, done, pass, err_count, fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outputs=%h, required 0", {a, b, c0, busy, done, pass, err_count, fail_vec});
        end
        @(negedge clk);
        rst = 1'b0;
        do_run("after_rst", 0, -1);
    endtask

    task automatic test_random_faults();
        for (int it = 0; it < 4; it++) begin
            for (int v = 0; v < NV; v++)
                ftab[v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            repeat ($urandom_range(0, 4)) @(posedge clk);
            do_run("random", 3, -1);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        fault_mode = 0;
        for (int v = 0; v < NV; v++) ftab[v] = 2'b00;
        rst   = 1'b1;
        start = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_good_adder();
        test_carry_stuck();
        test_inverted_sum();
        test_restart_ignored();
        test_start_in_done();
        test_async_reset();
        test_random_faults();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
